parking_lot_ctrl: RTL and testbench

//  Lot-level controller behind the entrance/exit car detector. Counts enter/exit

---
 rtl/parking_lot_ctrl_pkg.sv | 15 +
 rtl/parking_lot_ctrl_if.sv | 30 +++
 rtl/parking_lot_ctrl_occupancy_counter.sv | 43 ++++
 rtl/parking_lot_ctrl.sv | 127 ++++++++++++
 tb/tb_parking_lot_ctrl.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/parking_lot_ctrl_pkg.sv
// Shared types and defaults for the parking lot controller.
// Optional statistics outputs are enabled by defining PARKING_STATS_EN.
package parking_pkg;

  typedef enum logic [1:0] {
    G_CLOSED = 2'd0,
    G_OPEN   = 2'd1,
    G_HOLD   = 2'd2
  } gate_state_t;

  localparam int STATS_W              = 16;
  localparam int DEFAULT_CAPACITY     = 16;
  localparam int DEFAULT_GATE_TIMEOUT = 50;

endpackage

// File: rtl/parking_lot_ctrl_if.sv
// Detector, gate and status signals between the lot controller and its environment.
interface parking_lot_ctrl_if
  import parking_pkg::*;
#(
  parameter int CNT_W = 5
) ();

  logic               enter;
  logic               exit;
  logic               entry_req;
  logic               gate_open;
  logic [CNT_W-1:0]   occupancy;
  logic               full;
  logic               empty;
  logic               deny;
  logic               count_err;
  logic [STATS_W-1:0] total_entries;
  logic [CNT_W-1:0]   peak_occ;

  modport master (
    output enter, exit, entry_req,
    input  gate_open, occupancy, full, empty, deny, count_err, total_entries, peak_occ
  );

  modport slave (
    input  enter, exit, entry_req,
    output gate_open, occupancy, full, empty, deny, count_err, total_entries, peak_occ
  );

endinterface

// File: rtl/parking_lot_ctrl_occupancy_counter.sv
// Saturating up/down car counter with a sticky error flag for impossible moves.
module occupancy_counter #(
  parameter int CAPACITY = 16,
  parameter int CNT_W    = $clog2(CAPACITY + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             err
);

  logic [CNT_W-1:0] count_reg, count_next;
  logic             err_reg, err_next;

  // Simultaneous inc/dec cancel out even at the boundaries.
  always_comb begin
    count_next = count_reg;
    err_next   = err_reg;
    if (inc && !dec) begin
      if (count_reg == CNT_W'(CAPACITY)) err_next = 1'b1;
      else                               count_next = count_reg + 1'b1;
    end else if (dec && !inc) begin
      if (count_reg == '0) err_next = 1'b1;
      else                 count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      err_reg   <= err_next;
    end
  end

  assign count = count_reg;
  assign err   = err_reg;

endmodule

// File: rtl/parking_lot_ctrl.sv
// Lot controller: occupancy counting plus entry-gate sequencing with slot reservation.
// Define PARKING_STATS_EN to build the total_entries / peak_occ statistics.
module parking_lot_ctrl
  import parking_pkg::*;
#(
  parameter int CAPACITY     = DEFAULT_CAPACITY,
  parameter int CNT_W        = $clog2(CAPACITY + 1),
  parameter int GATE_TIMEOUT = DEFAULT_GATE_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  parking_lot_ctrl_if.slave bus
);

  localparam logic [1:0] S_CLOSED = 2'(G_CLOSED);
  localparam logic [1:0] S_OPEN   = 2'(G_OPEN);
  localparam logic [1:0] S_HOLD   = 2'(G_HOLD);
  localparam int         TMR_W    = $clog2(GATE_TIMEOUT);

  logic [1:0]       state_reg, state_next;
  logic [TMR_W-1:0] timer_reg, timer_next;
  logic             pending_reg, pending_next;
  logic             gate_open_reg, gate_open_next;
  logic             deny_reg, deny_next;
  logic [CNT_W-1:0] occupancy;
  logic [CNT_W:0]   committed;
  logic             full;

  occupancy_counter #(
    .CAPACITY (CAPACITY),
    .CNT_W    (CNT_W)
  ) u_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (bus.enter),
    .dec   (bus.exit),
    .count (occupancy),
    .err   (bus.count_err)
  );

  // A granted-but-not-yet-entered car already owns a slot.
  assign committed = {1'b0, occupancy} + {{CNT_W{1'b0}}, pending_reg};
  assign full      = committed >= (CNT_W + 1)'(CAPACITY);

  always_comb begin
    state_next   = state_reg;
    timer_next   = timer_reg;
    pending_next = pending_reg;
    deny_next    = 1'b0;
    case (state_reg)
      S_CLOSED: begin
        if (bus.entry_req) begin
          if (!full) begin
            state_next   = S_OPEN;
            pending_next = 1'b1;
            timer_next   = '0;
          end else begin
            state_next = S_HOLD;
            deny_next  = 1'b1;
          end
        end
      end
      S_OPEN: begin
        if (bus.enter || timer_reg == TMR_W'(GATE_TIMEOUT - 1)) begin
          state_next   = S_HOLD;
          pending_next = 1'b0;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      S_HOLD: begin
        // Wait for button release so one press yields one grant or deny.
        if (!bus.entry_req) state_next = S_CLOSED;
      end
      default: state_next = S_CLOSED;
    endcase
    gate_open_next = (state_next == S_OPEN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_CLOSED;
      timer_reg     <= '0;
      pending_reg   <= 1'b0;
      gate_open_reg <= 1'b0;
      deny_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      timer_reg     <= timer_next;
      pending_reg   <= pending_next;
      gate_open_reg <= gate_open_next;
      deny_reg      <= deny_next;
    end
  end

  assign bus.gate_open = gate_open_reg;
  assign bus.deny      = deny_reg;
  assign bus.occupancy = occupancy;
  assign bus.full      = full;
  assign bus.empty     = (occupancy == '0) && !pending_reg;

`ifdef PARKING_STATS_EN
  logic [STATS_W-1:0] total_entries_reg;
  logic [CNT_W-1:0]   peak_occ_reg;
  logic               accepted;

  // An enter is counted unless it saturated against a full lot.
  assign accepted = bus.enter && !(!bus.exit && occupancy == CNT_W'(CAPACITY));

  always_ff @(posedge clk) begin
    if (reset) begin
      total_entries_reg <= '0;
      peak_occ_reg      <= '0;
    end else begin
      if (accepted) total_entries_reg <= total_entries_reg + 1'b1;
      if (occupancy > peak_occ_reg) peak_occ_reg <= occupancy;
    end
  end

  assign bus.total_entries = total_entries_reg;
  assign bus.peak_occ      = peak_occ_reg;
`else
  assign bus.total_entries = '0;
  assign bus.peak_occ      = '0;
`endif

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// Directed bench for parking_lot_ctrl (CAPACITY=2, GATE_TIMEOUT=50): vector table plus corner sequences.
module tb_parking_lot_ctrl;

  localparam int CAP   = 2;
  localparam int TMO   = 50;
  localparam int CNT_W = $clog2(CAP + 1);

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  parking_lot_ctrl_if #(.CNT_W(CNT_W)) bus ();

  parking_lot_ctrl #(
    .CAPACITY     (CAP),
    .CNT_W        (CNT_W),
    .GATE_TIMEOUT (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic en, ex, req;
    logic gate;
    int   occ;
    logic full, empty, deny, err;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  function automatic vec_t mk(logic en, logic ex, logic req, logic gate, int occ,
                              logic full, logic empty, logic deny, logic err);
    vec_t v;
    v.en = en; v.ex = ex; v.req = req; v.gate = gate; v.occ = occ;
    v.full = full; v.empty = empty; v.deny = deny; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic ex, input logic req);
    bus.enter     = en;
    bus.exit      = ex;
    bus.entry_req = req;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    chk("rst_gate",  int'(bus.gate_open), 0);
    chk("rst_occ",   int'(bus.occupancy), 0);
    chk("rst_full",  int'(bus.full), 0);
    chk("rst_empty", int'(bus.empty), 1);
    chk("rst_deny",  int'(bus.deny), 0);
    chk("rst_err",   int'(bus.count_err), 0);
    chk("rst_total", int'(bus.total_entries), 0);
    chk("rst_peak",  int'(bus.peak_occ), 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive(1'b0, 1'b0, 1'b0);

    //              en ex req | gate occ full empty deny err
    vecs[0]  = mk(0, 0, 1,  1, 0, 0, 0, 0, 0);  // grant, slot reserved
    vecs[1]  = mk(0, 0, 1,  1, 0, 0, 0, 0, 0);
    vecs[2]  = mk(1, 0, 1,  0, 1, 0, 0, 0, 0);  // car in, gate drops
    vecs[3]  = mk(0, 0, 1,  0, 1, 0, 0, 0, 0);  // held button: no regrant
    vecs[4]  = mk(0, 0, 0,  0, 1, 0, 0, 0, 0);
    vecs[5]  = mk(0, 0, 1,  1, 1, 1, 0, 0, 0);  // 2nd grant fills the lot
    vecs[6]  = mk(0, 0, 0,  1, 1, 1, 0, 0, 0);
    vecs[7]  = mk(0, 0, 1,  1, 1, 1, 0, 0, 0);  // press while open ignored
    vecs[8]  = mk(1, 0, 1,  0, 2, 1, 0, 0, 0);
    vecs[9]  = mk(0, 0, 0,  0, 2, 1, 0, 0, 0);
    vecs[10] = mk(0, 0, 1,  0, 2, 1, 0, 1, 0);  // deny pulse
    vecs[11] = mk(0, 0, 1,  0, 2, 1, 0, 0, 0);
    vecs[12] = mk(0, 0, 0,  0, 2, 1, 0, 0, 0);
    vecs[13] = mk(0, 1, 0,  0, 1, 0, 0, 0, 0);
    vecs[14] = mk(1, 1, 0,  0, 1, 0, 0, 0, 0);  // enter&exit cancel
    vecs[15] = mk(0, 1, 0,  0, 0, 0, 1, 0, 0);
    vecs[16] = mk(0, 1, 0,  0, 0, 0, 1, 0, 1);  // exit at 0
    vecs[17] = mk(0, 0, 0,  0, 0, 0, 1, 0, 1);  // sticky
    vecs[18] = mk(1, 0, 0,  0, 1, 0, 0, 0, 1);  // tailgater counts
    vecs[19] = mk(1, 0, 0,  0, 2, 1, 0, 0, 1);
    vecs[20] = mk(1, 0, 0,  0, 2, 1, 0, 0, 1);  // saturates at CAPACITY

    do_reset();

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].en, vecs[i].ex, vecs[i].req);
      tick();
      $display("vec %0d: en=%0d ex=%0d req=%0d -> gate=%0d occ=%0d full=%0d empty=%0d deny=%0d err=%0d",
               i, vecs[i].en, vecs[i].ex, vecs[i].req, bus.gate_open, bus.occupancy,
               bus.full, bus.empty, bus.deny, bus.count_err);
      chk($sformatf("v%0d_gate", i),  int'(bus.gate_open), int'(vecs[i].gate));
      chk($sformatf("v%0d_occ", i),   int'(bus.occupancy), vecs[i].occ);
      chk($sformatf("v%0d_full", i),  int'(bus.full),      int'(vecs[i].full));
      chk($sformatf("v%0d_empty", i), int'(bus.empty),     int'(vecs[i].empty));
      chk($sformatf("v%0d_deny", i),  int'(bus.deny),      int'(vecs[i].deny));
      chk($sformatf("v%0d_err", i),   int'(bus.count_err), int'(vecs[i].err));
    end

    // Timeout: one car inside, grant with no enter; gate open exactly TMO cycles.
    do_reset();
    drive(1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b1);
    tick();
    $display("timeout: grant gate=%0d full=%0d", bus.gate_open, bus.full);
    chk("to_rise", int'(bus.gate_open), 1);
    chk("to_full_pending", int'(bus.full), 1);
    drive(1'b0, 1'b0, 1'b0);
    for (int k = 1; k < TMO; k++) begin
      tick();
      chk($sformatf("to_open_%0d", k), int'(bus.gate_open), 1);
    end
    tick();
    $display("timeout: after %0d cycles gate=%0d full=%0d occ=%0d", TMO, bus.gate_open, bus.full, bus.occupancy);
    chk("to_drop", int'(bus.gate_open), 0);
    chk("to_full_released", int'(bus.full), 0);
    chk("to_occ", int'(bus.occupancy), 1);

    // Reset while the gate is open.
    do_reset();
    drive(1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b1);
    tick();
    chk("ro_open", int'(bus.gate_open), 1);
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    $display("reset-open: gate=%0d occ=%0d empty=%0d full=%0d", bus.gate_open, bus.occupancy, bus.empty, bus.full);
    chk("ro_gate",  int'(bus.gate_open), 0);
    chk("ro_occ",   int'(bus.occupancy), 0);
    chk("ro_empty", int'(bus.empty), 1);
    chk("ro_full",  int'(bus.full), 0);

    // Statistics: 3 entries, 1 exit.
    do_reset();
    drive(1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b1, 1'b0); tick();
    drive(1'b1, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b0); tick();
    $display("stats: total=%0d peak=%0d occ=%0d", bus.total_entries, bus.peak_occ, bus.occupancy);
    chk("st_occ", int'(bus.occupancy), 2);
`ifdef PARKING_STATS_EN
    chk("st_total", int'(bus.total_entries), 3);
    chk("st_peak",  int'(bus.peak_occ), 2);
`else
    chk("st_total", int'(bus.total_entries), 0);
    chk("st_peak",  int'(bus.peak_occ), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
